// File: rtl/mul_normalizer_if.sv
// Handshake and data bundle for the FP multiplier normalization stage.
// The master side drives operands and out_ready; the slave side is the normalizer.
interface mul_normalizer_if;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] prod;
    logic [9:0]  exp_sum;
    logic        sign_in;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] mul_normalize;
    logic [7:0]  exp_out;
    logic        sign_out;
    logic        overflow;
    logic        underflow;
    logic        zero;

    modport master (
        output en, in_valid, prod, exp_sum, sign_in, out_ready,
        input  in_ready, out_valid, mul_normalize, exp_out, sign_out,
               overflow, underflow, zero
    );

    modport slave (
        input  en, in_valid, prod, exp_sum, sign_in, out_ready,
        output in_ready, out_valid, mul_normalize, exp_out, sign_out,
               overflow, underflow, zero
    );
endinterface

// File: rtl/mul_normalizer.sv
// Iterative normalization of a 48-bit mantissa product into fraction + G/R/S, exponent and flags.
// Define MUL_NORM_FAST_LZC_EN to finish left normalization in one cycle via a leading-zero count.
module mul_normalizer (
    input  logic            clk,
    input  logic            arst,
    mul_normalizer_if.slave bus
);
    // state    | meaning
    // S_IDLE   | waiting for an operand, in_ready while en
    // S_LSHIFT | left-normalizing W, decrementing E
    // S_RSHIFT | denormalizing W into S, incrementing E up to 1
    // S_DONE   | result held on outputs until out_ready
    typedef enum logic [1:0] {S_IDLE, S_LSHIFT, S_RSHIFT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [47:0]        w_q, w_d;
    logic signed [11:0] e_q, e_d;
    logic               s_q, s_d;
    logic               sign_q, sign_d;
    logic [25:0]        mn_q, mn_d;
    logic [7:0]         exp_q, exp_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               zero_q, zero_d;
    logic               load_out;

    logic [47:0]        w_acc;
    logic signed [11:0] e_acc;
    logic               s_acc;

    always_comb begin
        w_acc = bus.prod[47] ? {1'b0, bus.prod[47:1]} : bus.prod;
        s_acc = bus.prod[47] & bus.prod[0];
        e_acc = $signed({{2{bus.exp_sum[9]}}, bus.exp_sum})
              + (bus.prod[47] ? 12'sd1 : 12'sd0);
    end

`ifdef MUL_NORM_FAST_LZC_EN
    logic [5:0]         lzc;
    logic signed [11:0] e_m1;
    logic signed [11:0] lsh_n;

    always_comb begin
        lzc = 6'd47;
        for (int i = 0; i < 47; i++) begin
            if (w_q[i]) lzc = 6'(46 - i);
        end
        e_m1  = e_q - 12'sd1;
        lsh_n = ($signed({6'd0, lzc}) < e_m1) ? $signed({6'd0, lzc}) : e_m1;
    end
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            e_q     <= '0;
            s_q     <= 1'b0;
            sign_q  <= 1'b0;
            mn_q    <= '0;
            exp_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            e_q     <= e_d;
            s_q     <= s_d;
            sign_q  <= sign_d;
            if (load_out) begin
                mn_q   <= mn_d;
                exp_q  <= exp_d;
                ovf_q  <= ovf_d;
                unf_q  <= unf_d;
                zero_q <= zero_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        e_d     = e_q;
        s_d     = s_q;
        sign_d  = sign_q;
        if (bus.en) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        w_d    = w_acc;
                        e_d    = e_acc;
                        s_d    = s_acc;
                        sign_d = bus.sign_in;
                        if (w_acc == 48'd0) begin
                            state_d = S_DONE;
                        end else if (e_acc < -12'sd47) begin
                            // too far below the subnormal range: everything lands in sticky
                            w_d     = '0;
                            s_d     = 1'b1;
                            state_d = S_DONE;
                        end else if (e_acc < 12'sd1) begin
                            state_d = S_RSHIFT;
                        end else if (!w_acc[46] && e_acc > 12'sd1) begin
                            state_d = S_LSHIFT;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_LSHIFT: begin
`ifdef MUL_NORM_FAST_LZC_EN
                    w_d     = w_q << lsh_n[5:0];
                    e_d     = e_q - lsh_n;
                    state_d = S_DONE;
`else
                    w_d = {w_q[46:0], 1'b0};
                    e_d = e_q - 12'sd1;
                    if (w_d[46] || e_d == 12'sd1) state_d = S_DONE;
`endif
                end
                S_RSHIFT: begin
                    s_d = s_q | w_q[0];
                    w_d = {1'b0, w_q[47:1]};
                    e_d = e_q + 12'sd1;
                    if (e_d == 12'sd1) state_d = S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) state_d = S_IDLE;
                end
            endcase
        end
    end

    // Result packing from the values about to be registered on entry to DONE.
    always_comb begin
        load_out = bus.en && (state_q != S_DONE) && (state_d == S_DONE);
        zero_d   = (w_d == 48'd0) && !s_d;
        ovf_d    = 1'b0;
        mn_d     = {w_d[45:21], s_d | (|w_d[20:0])};
        exp_d    = w_d[46] ? e_d[7:0] : 8'd0;
        if (zero_d) begin
            mn_d  = '0;
            exp_d = '0;
        end else if (e_d >= 12'sd255) begin
            ovf_d = 1'b1;
            exp_d = 8'hFF;
            mn_d  = '0;
        end
        unf_d = (exp_d == 8'd0) && !zero_d;
    end

    always_comb begin
        bus.in_ready  = (state_q == S_IDLE) && bus.en;
        bus.out_valid = (state_q == S_DONE);
    end

    assign bus.mul_normalize = mn_q;
    assign bus.exp_out       = exp_q;
    assign bus.sign_out      = sign_q;
    assign bus.overflow      = ovf_q;
    assign bus.underflow     = unf_q;
    assign bus.zero          = zero_q;
endmodule

// File: tb/tb_mul_normalizer.sv
// Directed bench for mul_normalizer with a closed-form reference model and a per-cycle monitor.
// Expected latencies follow MUL_NORM_FAST_LZC_EN when it is defined for the build.
module tb_mul_normalizer;
    logic clk = 1'b0;
    logic arst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    mul_normalizer_if bus ();

    mul_normalizer dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [25:0] mn;
        logic [7:0]  ex;
        logic        sg;
        logic        ov;
        logic        un;
        logic        zr;
        int          lat;
    } res_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Closed-form: locate the leading one, pick the shift count from the exponent, shift once.
    function automatic res_t model(input logic [47:0] prod, input int exp_sum, input logic sgn);
        res_t        r;
        int          p;
        int          e;
        int          k;
        logic [95:0] x;
        logic [47:0] w;
        r = '{mn: '0, ex: '0, sg: sgn, ov: 1'b0, un: 1'b0, zr: 1'b0, lat: 1};
        if (prod == 48'd0) begin
            r.zr = 1'b1;
            return r;
        end
        p = 0;
        for (int i = 0; i < 48; i++) if (prod[i]) p = i;
        e = exp_sum;
        x = {prod, 48'd0};
        if (p == 47) begin
            x = x >> 1;
            e = e + 1;
            p = 46;
        end
        if (e < -47) begin
            r.mn = 26'd1;
            r.un = 1'b1;
            return r;
        end
        if (e < 1) begin
            k     = 1 - e;
            x     = x >> k;
            e     = 1;
            r.lat = 1 + k;
        end else if (p < 46) begin
            k = ((46 - p) < (e - 1)) ? (46 - p) : (e - 1);
            x = x << k;
            e = e - k;
`ifdef MUL_NORM_FAST_LZC_EN
            r.lat = (k > 0) ? 2 : 1;
`else
            r.lat = 1 + k;
`endif
        end
        w    = x[95:48];
        r.mn = {w[45:21], (|w[20:0]) | (|x[47:0])};
        r.ex = w[46] ? 8'(e) : 8'd0;
        if (e >= 255) begin
            r.ov = 1'b1;
            r.ex = 8'hFF;
            r.mn = '0;
        end
        r.un = (r.ex == 8'd0);
        return r;
    endfunction

    // Monitor: one transaction in flight at most; checks handshake and results every cycle.
    res_t cur;
    bit   pending = 1'b0;
    bit   seen    = 1'b0;
    bit   prev_en = 1'b0;
    int   lat_cnt = 0;

    always @(negedge clk) begin
        if (arst) begin
            pending = 1'b0;
        end else begin
            chk("in_ready", 64'(bus.in_ready), 64'(bus.en && !pending));
            if (pending) begin
                if (prev_en) lat_cnt++;
                prev_en = bus.en;
                if (bus.out_valid) begin
                    if (!seen) begin
                        chk("latency_en_cycles", 64'(lat_cnt), 64'(cur.lat));
                        seen = 1'b1;
                    end
                    chk("result", {bus.mul_normalize, bus.exp_out, bus.sign_out,
                                   bus.overflow, bus.underflow, bus.zero},
                                  {cur.mn, cur.ex, cur.sg, cur.ov, cur.un, cur.zr});
                    if (bus.out_ready && bus.en) pending = 1'b0;
                end
            end else begin
                chk("out_valid_idle", 64'(bus.out_valid), 64'd0);
                if (bus.in_valid && bus.in_ready) begin
                    cur     = model(bus.prod, int'($signed(bus.exp_sum)), bus.sign_in);
                    pending = 1'b1;
                    seen    = 1'b0;
                    lat_cnt = 0;
                    prev_en = 1'b1;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accept edge.
    task automatic send(input logic [47:0] p, input logic [9:0] es, input logic s);
        bit ok;
        ok           = 1'b0;
        bus.prod     = p;
        bus.exp_sum  = es;
        bus.sign_in  = s;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Counts edges from the accept edge (inclusive) until out_valid; gap en-low edges after accept.
    task automatic wait_result(input int gap, output int lat);
        int n;
        n      = 1;
        bus.en = (gap > 0) ? 1'b0 : 1'b1;
        @(negedge clk);
        while (!bus.out_valid && n < 200) begin
            @(posedge clk);
            n++;
            #1 bus.en = (n <= gap) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        if (!bus.out_valid) chk("result_timeout", 64'd0, 64'd1);
        lat = n;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (!bus.out_valid) break;
        end
    endtask

    task automatic run(input logic [47:0] p, input logic [9:0] es, input logic s,
                       input int gap, output int lat);
        send(p, es, s);
        wait_result(gap, lat);
        drain();
    endtask

    logic [47:0] tv_prod [4];
    logic [9:0]  tv_exp  [4];
    res_t        m;
    int          lat;
    int          lat_left;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, required finish before 1ms");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef MUL_NORM_FAST_LZC_EN
        lat_left = 2;
`else
        lat_left = 24;
`endif
        arst          = 1'b1;
        bus.en        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.prod      = '0;
        bus.exp_sum   = '0;
        bus.sign_in   = 1'b0;
        bus.out_ready = 1'b1;

        @(negedge clk);
        chk("reset_outputs", {bus.mul_normalize, bus.exp_out, bus.sign_out, bus.overflow,
                              bus.underflow, bus.zero, bus.out_valid}, 64'd0);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1 arst = 1'b0;

        // Pin the reference model to hand-computed values.
        m = model(48'h900000000000, 127, 1'b0);
        chk("model_1p5_mn", 64'(m.mn), 64'h0800000);
        chk("model_1p5_exp", 64'(m.ex), 64'd128);
        m = model(48'h400000000000, 127, 1'b0);
        chk("model_1p0", {m.mn, m.ex}, {26'd0, 8'd127});
        m = model(48'h000000800000, 100, 1'b0);
        chk("model_left_exp", 64'(m.ex), 64'd77);
        chk("model_left_lat", 64'(m.lat), 64'(lat_left));
        m = model(48'h400000000000, -1, 1'b0);
        chk("model_subn", {m.mn, m.ex, m.un}, {26'h1000000, 8'd0, 1'b1});
        chk("model_subn_lat", 64'(m.lat), 64'd3);
        m = model(48'h400000000001, -50, 1'b0);
        chk("model_flush", {m.mn, m.ex, m.un}, {26'h0000001, 8'd0, 1'b1});
        m = model(48'h400000000000, 255, 1'b0);
        chk("model_ovf", {m.mn, m.ex, m.ov}, {26'd0, 8'hFF, 1'b1});
        m = model(48'd0, 12, 1'b0);
        chk("model_zero", {m.zr, m.ex, m.un}, {1'b1, 8'd0, 1'b0});

        run(48'h900000000000, 10'sd127, 1'b1, 0, lat);
        chk("lat_1p5", 64'(lat), 64'd1);

        // 1.0 x 1.0 with a 5-cycle downstream stall
        bus.out_ready = 1'b0;
        send(48'h400000000000, 10'sd127, 1'b0);
        wait_result(0, lat);
        chk("lat_1p0", 64'(lat), 64'd1);
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_stall", {bus.out_valid, bus.in_ready}, {1'b0, 1'b1});

        run(48'd0, 10'sd12, 1'b0, 0, lat);
        run(48'h400000000000, 10'sd255, 1'b0, 0, lat);

        run(48'h000000800000, 10'sd100, 1'b0, 0, lat);
        chk("lat_left", 64'(lat), 64'(lat_left));

        run(48'h400000000000, -10'sd1, 1'b0, 0, lat);
        chk("lat_subn", 64'(lat), 64'd3);

        run(48'h400000000001, -10'sd50, 1'b1, 0, lat);
        chk("lat_flush", 64'(lat), 64'd1);

        run(48'h400000000000, -10'sd1, 1'b0, 3, lat);
        chk("lat_subn_en_gap", 64'(lat), 64'd6);

        // Reset pulse while left-normalizing; sign_out is 1 from the sent operand.
        send(48'h000000800000, 10'sd100, 1'b1);
        @(posedge clk);
        #1 arst = 1'b1;
        @(negedge clk);
        chk("arst_mid_outputs", {bus.mul_normalize, bus.exp_out, bus.sign_out, bus.overflow,
                                 bus.underflow, bus.zero, bus.out_valid}, 64'd0);
        chk("arst_mid_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1 arst = 1'b0;

        tv_prod[0] = 48'h7FFFFFFFFFFF; tv_exp[0] = 10'sd10;
        tv_prod[1] = 48'h000000000001; tv_exp[1] = 10'sd5;
        tv_prod[2] = 48'hFFFFFFFFFFFF; tv_exp[2] = -10'sd20;
        tv_prod[3] = 48'hC00000000001; tv_exp[3] = 10'sd254;
        for (int i = 0; i < 4; i++) run(tv_prod[i], tv_exp[i], 1'(i), 0, lat);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
